datapath_ctrl: RTL and testbench

Instruction sequencer for the 4-register, 32-bit ALU datapath. It accepts 16-bit micro-instructions over a valid/ready handshake and drives the datapath's read addresses, write address, ALU opcode and write enable. Each instruction can repeat its register-to-register operation up to 16 times, with optional early termination on ALU carry-out. It sits between an instruction source (testbench, ROM or host) and the datapath, and is the only agent that asserts the datapath write enable.

---
 rtl/datapath_ctrl_pkg.sv | 33 +++
 rtl/datapath_ctrl.sv | 83 ++++++++
 tb/tb_datapath_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath instruction sequencer:
// micro-instruction layout and controller state encoding.
package datapath_ctrl_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int REP_MSB = 6;
    localparam int REP_LSB = 3;
    localparam int HOC_BIT = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] rep;
        logic       hoc;
        logic [1:0] rsvd;
    } instr_t;

endpackage

// File: rtl/datapath_ctrl.sv
// Instruction sequencer: accepts micro-instructions and drives the
// datapath register addresses, ALU opcode and write enable.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        cout,
    output logic [1:0]  addr1,
    output logic [1:0]  addr2,
    output logic [1:0]  addr3,
    output logic [2:0]  alu,
    output logic        wr,
    output logic        busy,
    output logic        done,
    output logic        carry_flag
);

    state_t     state, state_n;
    instr_t     ir;
    logic [3:0] cnt;
    logic       fin;
    logic       accept;

    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        wr          = 1'b0;
        busy        = 1'b0;
        addr1       = '0;
        addr2       = '0;
        addr3       = '0;
        alu         = '0;
        fin         = 1'b0;
        accept      = 1'b0;
        unique case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid)
                    state_n = S_ISSUE;
            end
            S_ISSUE: begin
                wr    = 1'b1;
                busy  = 1'b1;
                addr1 = ir.rs1;
                addr2 = ir.rs2;
                addr3 = ir.rd;
                alu   = ir.op;
                fin   = (cnt == 4'd0) || (ir.hoc && cout);
                if (fin)
                    state_n = S_IDLE;
            end
        endcase
    end

    // Decrement only while issues remain, so cnt cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ir         <= '0;
            cnt        <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            done  <= fin;
            if (accept) begin
                ir         <= instr_t'(instr);
                cnt        <= instr[REP_MSB:REP_LSB];
                carry_flag <= 1'b0;
            end else if (state == S_ISSUE) begin
                carry_flag <= carry_flag | cout;
                if (!fin)
                    cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for the datapath instruction sequencer.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        cout = 1'b0;
    logic [1:0]  addr1, addr2, addr3;
    logic [2:0]  alu;
    logic        wr, busy, done, carry_flag;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    datapath_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cout(cout), .addr1(addr1), .addr2(addr2),
        .addr3(addr3), .alu(alu), .wr(wr), .busy(busy), .done(done),
        .carry_flag(carry_flag)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Accepts one instruction and runs it; cout is driven per issue
    // cycle from mask. Reports writes seen and the done cycle (0 = none).
    task automatic issue(input logic [15:0] ins, input logic [15:0] mask,
                         output int nwr, output int done_cyc);
        nwr = 0;
        done_cyc = 0;
        instr = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (wr) begin
                cout = mask[nwr[3:0]];
                nwr++;
            end else begin
                cout = 1'b0;
            end
            step();
        end
        cout = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if ({wr, busy, done, carry_flag} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags got %b want 0000", {wr, busy, done, carry_flag});
        end
        compared++;
        if (instr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready got %b want 1", instr_ready);
        end
        compared++;
        if ({addr1, addr2, addr3, alu} !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_addr_alu got %h want 0", {addr1, addr2, addr3, alu});
        end
    endtask

    task automatic test_single;
        instr = 16'h5B00;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        compared++;
        if ({wr, busy, instr_ready} !== 3'b110) begin
            mismatched++;
            $display("FAIL single_c1_ctl got %b want 110", {wr, busy, instr_ready});
        end
        compared++;
        if ({addr1, addr2, addr3, alu} !== {2'd1, 2'd2, 2'd3, 3'd2}) begin
            mismatched++;
            $display("FAIL single_c1_fields got %h want %h",
                     {addr1, addr2, addr3, alu}, {2'd1, 2'd2, 2'd3, 3'd2});
        end
        step();
        compared++;
        if ({wr, done, instr_ready} !== 3'b011) begin
            mismatched++;
            $display("FAIL single_c2 got %b want 011", {wr, done, instr_ready});
        end
        step();
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL single_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_repeat;
        int n, d;
        issue(16'h5B18, 16'h0000, n, d);
        compared++;
        if (n != 4) begin
            mismatched++;
            $display("FAIL repeat_writes got %0d want 4", n);
        end
        compared++;
        if (d != 5) begin
            mismatched++;
            $display("FAIL repeat_done_cycle got %0d want 5", d);
        end
        compared++;
        if (carry_flag !== 1'b0) begin
            mismatched++;
            $display("FAIL repeat_carry got %b want 0", carry_flag);
        end
    endtask

    task automatic test_halt_on_carry;
        int n, d;
        issue(16'h5B7C, 16'h0004, n, d);
        compared++;
        if (n != 3) begin
            mismatched++;
            $display("FAIL hoc_writes got %0d want 3", n);
        end
        compared++;
        if (d != 4) begin
            mismatched++;
            $display("FAIL hoc_done_cycle got %0d want 4", d);
        end
        compared++;
        if (carry_flag !== 1'b1) begin
            mismatched++;
            $display("FAIL hoc_carry got %b want 1", carry_flag);
        end
    endtask

    task automatic test_no_halt;
        int n, d;
        issue(16'h5B78, 16'h0004, n, d);
        compared++;
        if (n != 16) begin
            mismatched++;
            $display("FAIL nohoc_writes got %0d want 16", n);
        end
        compared++;
        if (d != 17) begin
            mismatched++;
            $display("FAIL nohoc_done_cycle got %0d want 17", d);
        end
        step();
        step();
        step();
        compared++;
        if (carry_flag !== 1'b1) begin
            mismatched++;
            $display("FAIL nohoc_carry_hold got %b want 1", carry_flag);
        end
    endtask

    task automatic test_back_to_back;
        instr = 16'h5B08;
        instr_valid = 1'b1;
        step();
        instr = 16'h2480;
        compared++;
        if ({wr, instr_ready, carry_flag, alu} !== {3'b100, 3'd2}) begin
            mismatched++;
            $display("FAIL b2b_c1 got %b want 100010", {wr, instr_ready, carry_flag, alu});
        end
        step();
        compared++;
        if ({wr, instr_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL b2b_c2 got %b want 10", {wr, instr_ready});
        end
        step();
        compared++;
        if ({wr, done, instr_ready} !== 3'b011) begin
            mismatched++;
            $display("FAIL b2b_c3 got %b want 011", {wr, done, instr_ready});
        end
        step();
        instr_valid = 1'b0;
        compared++;
        if ({wr, done, addr1, addr2, addr3, alu} !== {2'b10, 2'd2, 2'd1, 2'd0, 3'd1}) begin
            mismatched++;
            $display("FAIL b2b_c4 got %h want %h", {wr, done, addr1, addr2, addr3, alu},
                     {2'b10, 2'd2, 2'd1, 2'd0, 3'd1});
        end
        step();
        compared++;
        if ({wr, done} !== 2'b01) begin
            mismatched++;
            $display("FAIL b2b_c5 got %b want 01", {wr, done});
        end
        step();
        compared++;
        if ({wr, done, busy} !== 3'b000) begin
            mismatched++;
            $display("FAIL b2b_no_recapture got %b want 000", {wr, done, busy});
        end
    endtask

    task automatic test_reset_mid;
        instr = 16'h5B18;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        cout = 1'b1;
        step();
        cout = 1'b0;
        compared++;
        if ({wr, carry_flag} !== 2'b11) begin
            mismatched++;
            $display("FAIL rstmid_pre got %b want 11", {wr, carry_flag});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if ({wr, done, carry_flag, instr_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL rstmid_post got %b want 0001", {wr, done, carry_flag, instr_ready});
        end
        step();
        compared++;
        if ({wr, done} !== 2'b00) begin
            mismatched++;
            $display("FAIL rstmid_after got %b want 00", {wr, done});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_halt_on_carry();
        test_no_halt();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
